// File: rtl/fp_divider_if.sv
// Handshake and data bundle for the sequential FP divider.
interface fp_divider_if;
  logic        start;
  logic [31:0] X;
  logic [31:0] Y;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        inf;
  logic        nan;
  logic        zero;
  logic        overflow;
  logic        underflow;

  modport master (output start, X, Y,
                  input  busy, done, result, inf, nan, zero, overflow, underflow);
  modport slave  (input  start, X, Y,
                  output busy, done, result, inf, nan, zero, overflow, underflow);
endinterface

// File: rtl/fp_divider.sv
// IEEE-754 single-precision divider, X / Y, truncating; restoring mantissa
// divide retires one quotient bit per clock under a start/done handshake.
module fp_divider (
  input  logic           clk,
  input  logic           reset,
  fp_divider_if.slave    bus
);
  localparam int QBITS = 25;

  typedef enum logic [2:0] {IDLE, CLASSIFY, DIV, NORM, DONE} state_t;
  state_t state, state_nx;

  logic [31:0]       x_q, y_q, result_q;
  logic              inf_q, nan_q, zero_q, ovf_q, unf_q, done_q;
  logic              sgn;
  logic signed [9:0] e_q, ef;
  logic [23:0]       my_q;
  logic [QBITS-1:0]  r_q, q_q, r_diff;
  logic [4:0]        cnt_q;
  logic              special;

  // Exponent-0 operands are flushed to zero.
  logic x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
  assign x_nan  = (x_q[30:23] == 8'hFF) && (x_q[22:0] != 23'd0);
  assign y_nan  = (y_q[30:23] == 8'hFF) && (y_q[22:0] != 23'd0);
  assign x_inf  = (x_q[30:23] == 8'hFF) && (x_q[22:0] == 23'd0);
  assign y_inf  = (y_q[30:23] == 8'hFF) && (y_q[22:0] == 23'd0);
  assign x_zero = (x_q[30:23] == 8'h00);
  assign y_zero = (y_q[30:23] == 8'h00);
  assign sgn    = x_q[31] ^ y_q[31];

  assign special = x_nan | y_nan | x_inf | y_inf | x_zero | y_zero;
  assign r_diff  = r_q - {1'b0, my_q};
  assign ef      = q_q[QBITS-1] ? e_q : e_q - 10'sd1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (bus.start) state_nx = CLASSIFY;
      CLASSIFY: state_nx = special ? DONE : DIV;
      DIV:      if (cnt_q == 5'd0) state_nx = NORM;
      NORM:     state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0; y_q <= '0; result_q <= '0;
      inf_q <= 1'b0; nan_q <= 1'b0; zero_q <= 1'b0; ovf_q <= 1'b0; unf_q <= 1'b0;
      done_q <= 1'b0;
      e_q <= '0; my_q <= '0; r_q <= '0; q_q <= '0; cnt_q <= '0;
    end else begin
      done_q <= (state == DONE);
      case (state)
        IDLE: if (bus.start) begin
          x_q <= bus.X;
          y_q <= bus.Y;
        end
        CLASSIFY: begin
          if (special) begin
            {inf_q, nan_q, zero_q, ovf_q, unf_q} <= 5'b0;
            if (x_nan | y_nan | (x_zero & y_zero) | (x_inf & y_inf)) begin
              result_q <= 32'h7FC00000; nan_q <= 1'b1;
            end else if (x_inf | y_zero) begin
              result_q <= {sgn, 8'hFF, 23'd0}; inf_q <= 1'b1;
            end else begin
              result_q <= {sgn, 31'd0}; zero_q <= 1'b1;
            end
          end
          e_q   <= $signed({2'b00, x_q[30:23]}) - $signed({2'b00, y_q[30:23]}) + 10'sd127;
          my_q  <= {1'b1, y_q[22:0]};
          r_q   <= {2'b01, x_q[22:0]};
          q_q   <= '0;
          cnt_q <= 5'd24;
        end
        DIV: begin
          if (r_q >= {1'b0, my_q}) begin
            q_q <= {q_q[QBITS-2:0], 1'b1};
            r_q <= {r_diff[QBITS-2:0], 1'b0};
          end else begin
            q_q <= {q_q[QBITS-2:0], 1'b0};
            r_q <= {r_q[QBITS-2:0], 1'b0};
          end
          if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
        end
        NORM: begin
          {inf_q, nan_q, zero_q, ovf_q, unf_q} <= 5'b0;
          if (ef >= 10'sd255) begin
            result_q <= {sgn, 8'hFF, 23'd0}; ovf_q <= 1'b1;
          end else if (ef <= 10'sd0) begin
            result_q <= {sgn, 31'd0}; unf_q <= 1'b1;
          end else begin
            result_q <= {sgn, ef[7:0], q_q[QBITS-1] ? q_q[23:1] : q_q[22:0]};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.inf       = inf_q;
  assign bus.nan       = nan_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule
